regfile_read_arbiter: RTL and testbench

//   Round-robin arbiter sharing one register-file read port (the 32:1 mux-tree select)

---
 rtl/regfile_read_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_read_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Round-robin arbiter that shares one register-file read port among NUM_REQ
//   requesters. The winner's address drives the read mux select combinationally.
//   The mux output is captured into a one-deep response register, which is
//   returned together with the requester index.
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   req_valid[NUM_REQ]          per-requester request pending
//   req_addr[NUM_REQ*ADDR_W]    requester i address at [i*ADDR_W +: ADDR_W]
//   req_ready[NUM_REQ]          one-hot grant (accept = valid & ready)
//   rf_read_addr[ADDR_W]        select to the register-file read mux
//   rf_read_data[DATA_W]        combinational read data for rf_read_addr
//   rsp_valid/rsp_id/rsp_data   response register contents
//   rsp_ready                   consumer accepts the response
module regfile_read_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter bit ZERO_REG = 1'b1,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rf_read_addr,
    input  logic [DATA_W-1:0]         rf_read_data,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      rsp_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    winner;
    logic              found;
    logic              can_accept;
    logic              grant;
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];

    // Unpack the flat address bus into per-requester lanes.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    // Priority scan starting at rr_ptr. The first valid requester found wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // The mux select follows the winner even when the response slot is blocked.
    // This keeps the read path free of any dependency on the response state.
    assign rf_read_addr = found ? addr_arr[winner] : '0;

    assign can_accept = (state == EMPTY) || rsp_ready;
    // Gating with reset keeps grants off while reset is held.
    assign grant      = found && can_accept && !reset;
    assign req_ready  = grant ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_valid  = (state == FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (grant) state_nxt = FULL;
            FULL:    if (grant) state_nxt = FULL;
                     else if (rsp_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rsp_id   <= winner;
                rsp_data <= (ZERO_REG && rf_read_addr == ADDR_W'(31)) ? '0 : rf_read_data;
                rr_ptr   <= (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
module tb_regfile_read_arbiter;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 64;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    req_ready;
    logic [AW-1:0]    rf_read_addr;
    logic [DW-1:0]    rf_read_data;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             rsp_ready;

    logic [DW-1:0] regs [32];
    int passed = 0;
    int total  = 0;

    assign rf_read_data = regs[rf_read_addr];

    regfile_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; req_valid = '0;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; req_valid = 4'b1111; rsp_ready = 1; req_addr = '0;
        step();
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", rsp_valid); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL rst_id got %0d exp 0", rsp_id); else passed++;
        total++; if (rsp_data !== 64'd0) $display("FAIL rst_data got %h exp 0", rsp_data); else passed++;
        total++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got %b exp 0000", req_ready); else passed++;
        req_valid = '0;
        step();
        reset = 0;
    endtask

    task automatic test_basic_read();
        regs[5] = 64'hDEAD_BEEF;
        req_addr[0*AW +: AW] = 5'd5; req_valid = 4'b0001; rsp_ready = 1;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL t1_ready got %b exp 0001", req_ready); else passed++;
        total++; if (rf_read_addr !== 5'd5) $display("FAIL t1_addr got %0d exp 5", rf_read_addr); else passed++;
        step();
        req_valid = '0;
        total++; if (rsp_valid !== 1'b1) $display("FAIL t1_rsp_valid got %b exp 1", rsp_valid); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL t1_rsp_id got %0d exp 0", rsp_id); else passed++;
        total++; if (rsp_data !== 64'hDEAD_BEEF) $display("FAIL t1_rsp_data got %h exp deadbeef", rsp_data); else passed++;
        #1;
        total++; if (rf_read_addr !== 5'd0) $display("FAIL idle_addr got %0d exp 0", rf_read_addr); else passed++;
        step();
        total++; if (rsp_valid !== 1'b0) $display("FAIL idle_valid got %b exp 0", rsp_valid); else passed++;
        total++; if (rsp_data !== 64'hDEAD_BEEF) $display("FAIL idle_retain got %h exp deadbeef", rsp_data); else passed++;
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = AW'(10 + i);
            regs[10 + i] = 64'(100 + i);
        end
        req_valid = 4'b1111; rsp_ready = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (req_ready !== (4'b0001 << exp_seq[c]))
                $display("FAIL rr_grant%0d got %b exp %b", c, req_ready, 4'b0001 << exp_seq[c]);
            else passed++;
            step();
            total++;
            if (rsp_id !== 2'(exp_seq[c]) || rsp_data !== 64'(100 + exp_seq[c]))
                $display("FAIL rr_rsp%0d got id %0d data %0d exp id %0d data %0d",
                         c, rsp_id, rsp_data, exp_seq[c], 100 + exp_seq[c]);
            else passed++;
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        regs[7] = 64'h77;
        req_addr[2*AW +: AW] = 5'd7; req_valid = 4'b0100; rsp_ready = 1;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL bp_first got %b exp 0100", req_ready); else passed++;
        step();
        rsp_ready = 0; regs[7] = 64'h88;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d got %b exp 0000", c, req_ready); else passed++;
            step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 64'h77)
                $display("FAIL bp_hold%0d got v%b id %0d data %h exp v1 id 2 data 77", c, rsp_valid, rsp_id, rsp_data);
            else passed++;
        end
        rsp_ready = 1;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL bp_second got %b exp 0100", req_ready); else passed++;
        step();
        req_valid = '0;
        total++; if (rsp_data !== 64'h88) $display("FAIL bp_second_data got %h exp 88", rsp_data); else passed++;
        step();
    endtask

    task automatic test_zero_reg();
        regs[31] = 64'h1234;
        req_addr[1*AW +: AW] = 5'd31; req_valid = 4'b0010; rsp_ready = 1;
        #1;
        total++; if (rf_read_addr !== 5'd31) $display("FAIL xzr_addr got %0d exp 31", rf_read_addr); else passed++;
        step();
        req_valid = '0;
        total++; if (rsp_data !== 64'd0 || rsp_id !== 2'd1) $display("FAIL xzr_rsp got id %0d data %h exp id 1 data 0", rsp_id, rsp_data); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        // Grant req2 first so rr_ptr is 3 when reset arrives.
        regs[9] = 64'h99;
        req_addr[2*AW +: AW] = 5'd9; req_valid = 4'b0100; rsp_ready = 1;
        step();
        req_valid = '0; rsp_ready = 0;
        step();
        #2;
        reset = 1; req_valid = 4'b1001;
        #1;
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 64'd0) $display("FAIL midrst_clear got v%b data %h exp v0 data 0", rsp_valid, rsp_data); else passed++;
        total++; if (req_ready !== 4'b0000) $display("FAIL midrst_ready got %b exp 0000", req_ready); else passed++;
        step();
        reset = 0; rsp_ready = 1;
        req_addr[0*AW +: AW] = 5'd5; req_addr[3*AW +: AW] = 5'd7;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL midrst_prio got %b exp 0001", req_ready); else passed++;
        step();
        total++; if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) $display("FAIL midrst_rsp got v%b id %0d exp v1 id 0", rsp_valid, rsp_id); else passed++;
        #1;
        total++; if (req_ready !== 4'b1000) $display("FAIL midrst_next got %b exp 1000", req_ready); else passed++;
        step();
        req_valid = '0;
        step();
    endtask

    task automatic test_skip();
        do_reset();
        req_valid = 4'b0010; rsp_ready = 1;
        step();
        req_valid = 4'b1010;
        #1;
        total++; if (req_ready !== 4'b1000) $display("FAIL skip_first got %b exp 1000", req_ready); else passed++;
        step();
        total++; if (rsp_id !== 2'd3) $display("FAIL skip_id3 got %0d exp 3", rsp_id); else passed++;
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL skip_second got %b exp 0010", req_ready); else passed++;
        step();
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL skip_ptr got %b exp 0100", req_ready); else passed++;
        step();
        req_valid = '0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'(i) * 64'h0101;
        reset = 1; req_valid = '0; req_addr = '0; rsp_ready = 0;
        test_reset();
        test_basic_read();
        test_round_robin();
        test_backpressure();
        test_zero_reg();
        test_reset_mid();
        test_skip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
